// File: rtl/ray_plane_seq_if.sv
// Request/response bundle between the ray generator, the intersector and the shading stage.
// The master side issues ray/plane pairs and accepts results; the slave side is the engine.
interface ray_plane_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] normal;
  logic [95:0] v0;
  logic [95:0] origin;
  logic [95:0] dir;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] p_hit;
  logic [31:0] t_out;
  logic        hit;

  modport master (
    output in_valid, normal, v0, origin, dir, out_ready,
    input  in_ready, out_valid, p_hit, t_out, hit
  );

  modport slave (
    input  in_valid, normal, v0, origin, dir, out_ready,
    output in_ready, out_valid, p_hit, t_out, hit
  );
endinterface

// File: rtl/ray_plane_seq.sv
// Multi-cycle ray/plane intersector: one shared Q16.16 multiplier plus a 1-bit/cycle restoring divider.
// Result 58 cycles after accept (7 when den==0); held in DONE until out_ready, in_ready only in IDLE.
module ray_plane_seq (
  input logic            clk,
  input logic            reset,
  ray_plane_seq_if.slave bus
);
  localparam int DIV_BITS = 48;

  typedef enum logic [2:0] {S_IDLE, S_SUB, S_DOT, S_DIV, S_SCALE, S_DONE} state_t;
  state_t state, state_nxt;

  logic [95:0] normal_r, v0_r, origin_r, dir_r, d_r;
  logic [31:0] num_r, den_r, t_r;
  logic [95:0] p_r;
  logic        hit_r;
  logic [5:0]  cnt;
  logic [47:0] quo_r;
  logic [32:0] rem_r, dvs_r;
  logic        neg_r;

  logic [31:0]        mul_a, mul_b, mul_res, den_fin, sat_q, t_fin;
  logic signed [63:0] prod;
  logic [32:0]        num_mag, den_mag;
  logic [33:0]        rem_sh;
  logic               ge;
  logic [47:0]        quo_nxt;
  logic               accept;

  function automatic logic [31:0] comp(input logic [95:0] v, input logic [5:0] i);
    case (i)
      6'd0:    comp = v[95:64];
      6'd1:    comp = v[63:32];
      default: comp = v[31:0];
    endcase
  endfunction

  // Operand select for the single multiplier: DOT does num x,y,z then den x,y,z; SCALE does t*dir.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == S_DOT) begin
      mul_a = (cnt < 6'd3) ? comp(normal_r, cnt) : comp(normal_r, cnt - 6'd3);
      mul_b = (cnt < 6'd3) ? comp(d_r, cnt)      : comp(dir_r, cnt - 6'd3);
    end else if (state == S_SCALE) begin
      mul_a = t_r;
      mul_b = comp(dir_r, cnt);
    end
  end

  assign prod    = 64'($signed(mul_a)) * 64'($signed(mul_b));
  assign mul_res = 32'(prod >>> 16);
  assign den_fin = den_r + mul_res;

  // 33-bit magnitudes keep -2^31 exact.
  assign num_mag = num_r[31]   ? 33'd0 - {1'b1, num_r}   : {1'b0, num_r};
  assign den_mag = den_fin[31] ? 33'd0 - {1'b1, den_fin} : {1'b0, den_fin};

  // Dividend bits leave quo_r from the top while quotient bits enter at the bottom.
  assign rem_sh  = {rem_r, quo_r[47]};
  assign ge      = rem_sh >= {1'b0, dvs_r};
  assign quo_nxt = {quo_r[46:0], ge};
  assign sat_q   = (|quo_nxt[47:31]) ? 32'h7FFF_FFFF : quo_nxt[31:0];
  assign t_fin   = neg_r ? 32'd0 - sat_q : sat_q;

  assign accept  = bus.in_valid && (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = S_SUB;
      end
      S_SUB:   state_nxt = S_DOT;
      S_DOT:   if (cnt == 6'd5) state_nxt = (den_fin == 32'd0) ? S_DONE : S_DIV;
      S_DIV:   if (cnt == 6'(DIV_BITS - 1)) state_nxt = S_SCALE;
      S_SCALE: if (cnt == 6'd2) state_nxt = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      normal_r <= '0; v0_r <= '0; origin_r <= '0; dir_r <= '0; d_r <= '0;
      num_r <= '0; den_r <= '0; t_r <= '0; p_r <= '0; hit_r <= 1'b0;
      cnt <= '0; quo_r <= '0; rem_r <= '0; dvs_r <= '0; neg_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          normal_r <= bus.normal;
          v0_r     <= bus.v0;
          origin_r <= bus.origin;
          dir_r    <= bus.dir;
          num_r    <= '0;
          den_r    <= '0;
          cnt      <= '0;
        end
        S_SUB: d_r <= {v0_r[95:64] - origin_r[95:64],
                       v0_r[63:32] - origin_r[63:32],
                       v0_r[31:0]  - origin_r[31:0]};
        S_DOT: begin
          if (cnt < 6'd3) num_r <= num_r + mul_res;
          else            den_r <= den_fin;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd5) begin
            cnt <= '0;
            if (den_fin == 32'd0) begin
              t_r   <= '0;
              p_r   <= '0;
              hit_r <= 1'b0;
            end else begin
              rem_r <= '0;
              quo_r <= 48'({num_mag, 16'h0000});
              dvs_r <= den_mag;
              neg_r <= num_r[31] ^ den_fin[31];
            end
          end
        end
        S_DIV: begin
          rem_r <= ge ? 33'(rem_sh - {1'b0, dvs_r}) : rem_sh[32:0];
          quo_r <= quo_nxt;
          cnt   <= cnt + 6'd1;
          if (cnt == 6'(DIV_BITS - 1)) begin
            cnt   <= '0;
            t_r   <= t_fin;
            hit_r <= ~t_fin[31];
          end
        end
        S_SCALE: begin
          case (cnt)
            6'd0:    p_r[95:64] <= comp(origin_r, cnt) + mul_res;
            6'd1:    p_r[63:32] <= comp(origin_r, cnt) + mul_res;
            default: p_r[31:0]  <= comp(origin_r, cnt) + mul_res;
          endcase
          cnt <= (cnt == 6'd2) ? 6'd0 : cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.p_hit = p_r;
  assign bus.t_out = t_r;
  assign bus.hit   = hit_r;
endmodule
